// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int ADDR_W_DEFAULT = 18;
  localparam int DATA_W_DEFAULT = 16;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_SETUP,
    RD_SAMPLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_e;

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-request round-robin arbiter; on a tie the port that lost the last grant wins.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic reqA_i,
  input  logic reqB_i,
  input  logic update_i,
  output logic grantValid_o,
  output logic grantPort_o
);

  logic lastGrant_q;

  always_comb begin
    grantValid_o = reqA_i | reqB_i;
    grantPort_o  = PORT_A;
    if (reqA_i && reqB_i) begin
      grantPort_o = (lastGrant_q == PORT_A) ? PORT_B : PORT_A;
    end else if (reqB_i) begin
      grantPort_o = PORT_B;
    end
  end

  // Resetting to B lets A win the very first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant_q <= PORT_B;
    end else if (update_i && grantValid_o) begin
      lastGrant_q <= grantPort_o;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Front end to the single async SRAM: arbitrates fetch (A) and data (B) ports and sequences the pins.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aReq,
  input  logic [ADDR_W-1:0] aAddr,
  output logic              aAck,
  output logic [DATA_W-1:0] aData,
  input  logic              bReq,
  input  logic              bWe,
  input  logic [ADDR_W-1:0] bAddr,
  input  logic [DATA_W-1:0] bWdata,
  output logic              bAck,
  output logic [DATA_W-1:0] bData,
  output logic [ADDR_W-1:0] memAddrBus,
  inout  wire  [DATA_W-1:0] memDataBus,
  output logic              memEnable,
  output logic              memRead,
  output logic              memWrite
);

  state_e            state_q;
  logic              portId_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              driveEn_q;
  logic              ceN_q;
  logic              oeN_q;
  logic              weN_q;
  logic              aAck_q;
  logic              bAck_q;
  logic [DATA_W-1:0] aData_q;
  logic [DATA_W-1:0] bData_q;

  logic              grantValid;
  logic              grantPort;
  logic [ADDR_W-1:0] grantAddr;
  logic              grantWrite;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .reqA_i      (aReq),
    .reqB_i      (bReq),
    .update_i    (state_q == IDLE),
    .grantValid_o(grantValid),
    .grantPort_o (grantPort)
  );

  // Port A is read-only, so bWe only matters when B holds the grant.
  assign grantAddr  = (grantPort == PORT_B) ? bAddr : aAddr;
  assign grantWrite = (grantPort == PORT_B) && bWe;

  // All pin strobes are registered and set on the edge entering each state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      portId_q  <= PORT_A;
      memAddr_q <= '0;
      wdata_q   <= '0;
      driveEn_q <= 1'b0;
      ceN_q     <= 1'b1;
      oeN_q     <= 1'b1;
      weN_q     <= 1'b1;
      aAck_q    <= 1'b0;
      bAck_q    <= 1'b0;
      aData_q   <= '0;
      bData_q   <= '0;
    end else begin
      aAck_q <= 1'b0;
      bAck_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantValid) begin
            portId_q  <= grantPort;
            memAddr_q <= grantAddr;
            ceN_q     <= 1'b0;
            if (grantWrite) begin
              wdata_q   <= bWdata;
              driveEn_q <= 1'b1;
              state_q   <= WR_SETUP;
            end else begin
              oeN_q   <= 1'b0;
              state_q <= RD_SETUP;
            end
          end
        end
        RD_SETUP: begin
          state_q <= RD_SAMPLE;
        end
        RD_SAMPLE: begin
          if (portId_q == PORT_A) begin
            aData_q <= memDataBus;
            aAck_q  <= 1'b1;
          end else begin
            bData_q <= memDataBus;
            bAck_q  <= 1'b1;
          end
          ceN_q   <= 1'b1;
          oeN_q   <= 1'b1;
          state_q <= DONE;
        end
        WR_SETUP: begin
          weN_q   <= 1'b0;
          state_q <= WR_PULSE;
        end
        WR_PULSE: begin
          weN_q   <= 1'b1;
          state_q <= WR_HOLD;
        end
        WR_HOLD: begin
          ceN_q     <= 1'b1;
          driveEn_q <= 1'b0;
          bAck_q    <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          memAddr_q <= '0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign memDataBus = driveEn_q ? wdata_q : 'z;

  assign memAddrBus = memAddr_q;
  assign memEnable  = ceN_q;
  assign memRead    = oeN_q;
  assign memWrite   = weN_q;
  assign aAck       = aAck_q;
  assign bAck       = bAck_q;
  assign aData      = aData_q;
  assign bData      = bData_q;

endmodule
